// File: rtl/cmd_stream_assembler.sv
// cmd_stream_assembler: packs an 8-bit byte stream into N-byte words, buffers them in a FWFT FIFO and drives an AXI-Stream master (byte in, cmd_axis out, fifo level, timeout drop pulse)
module cmd_stream_assembler #(
  parameter int BYTES_PER_WORD = 4,
  parameter bit BIG_ENDIAN = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int W = 8*BYTES_PER_WORD,
  localparam int LW = $clog2(FIFO_DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  input  logic [7:0]    byte_data_i,
  output logic          cmd_axis_tvalid_o,
  input  logic          cmd_axis_tready_i,
  output logic [W-1:0]  cmd_axis_tdata_o,
  output logic [LW-1:0] fifo_level_o,
  output logic          timeout_drop_o
);
  localparam int IW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD-1);
  localparam logic [PW-1:0] PLAST = PW'(FIFO_DEPTH-1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES-1 : 0);
  logic [IW-1:0] idx;
  logic [IW-1:0] lane;
  logic [TW-1:0] cnt;
  logic [W-1:0]  word;
  logic [W-1:0]  word_next;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          push;
  logic          pop;
  logic          expire;
  assign byte_ready_o = !reset_i && !(idx == LAST && fifo_level_o == FULL);
  assign accept = byte_valid_i && byte_ready_o;
  assign push = accept && idx == LAST;
  assign pop = cmd_axis_tvalid_o && cmd_axis_tready_i;
  assign expire = TIMEOUT_CYCLES > 0 && idx != '0 && !accept && cnt == TLAST;
  assign cmd_axis_tvalid_o = fifo_level_o != '0;
  assign cmd_axis_tdata_o = cmd_axis_tvalid_o ? mem[rd_ptr] : '0;
  assign lane = BIG_ENDIAN ? LAST - idx : idx;
  always_comb begin
    word_next = word;
    word_next[8*lane +: 8] = byte_data_i;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      idx <= '0;
      cnt <= '0;
      word <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level_o <= '0;
      timeout_drop_o <= 1'b0;
    end else begin
      idx <= expire ? '0 : accept ? (idx == LAST ? '0 : idx + IW'(1)) : idx;
      cnt <= (accept || expire || idx == '0 || TIMEOUT_CYCLES == 0) ? '0 : cnt + TW'(1);
      word <= accept ? word_next : word;
      timeout_drop_o <= expire;
      wr_ptr <= push ? (wr_ptr == PLAST ? '0 : wr_ptr + PW'(1)) : wr_ptr;
      rd_ptr <= pop ? (rd_ptr == PLAST ? '0 : rd_ptr + PW'(1)) : rd_ptr;
      fifo_level_o <= fifo_level_o + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_next;
  end
endmodule

// File: tb/tb_cmd_stream_assembler.sv
// tb_cmd_stream_assembler: directed and random checks of cmd_stream_assembler against a byte/word queue model
module tb_cmd_stream_assembler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic bv_a, rdy_a, tv_a, tr_a, drop_a;
  logic [7:0] bd_a;
  logic [31:0] td_a;
  logic [2:0] lvl_a;
  logic bv_b, rdy_b, tv_b, tr_b, drop_b;
  logic [7:0] bd_b;
  logic [15:0] td_b;
  logic [2:0] lvl_b;
  int total = 0;
  int bad = 0;
  logic [7:0] pb[$];
  logic [31:0] wq[$];
  int idle = 0;
  bit drop_m = 1'b0;
  logic [7:0] bs [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  cmd_stream_assembler #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut_a (
    .clk(clk), .reset_i(rst), .byte_valid_i(bv_a), .byte_ready_o(rdy_a), .byte_data_i(bd_a),
    .cmd_axis_tvalid_o(tv_a), .cmd_axis_tready_i(tr_a), .cmd_axis_tdata_o(td_a),
    .fifo_level_o(lvl_a), .timeout_drop_o(drop_a));

  cmd_stream_assembler #(.BYTES_PER_WORD(2), .BIG_ENDIAN(0), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset_i(rst), .byte_valid_i(bv_b), .byte_ready_o(rdy_b), .byte_data_i(bd_b),
    .cmd_axis_tvalid_o(tv_b), .cmd_axis_tready_i(tr_b), .cmd_axis_tdata_o(td_b),
    .fifo_level_o(lvl_b), .timeout_drop_o(drop_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of dut_a: drive, compare against the model mid-cycle, then advance the model.
  task automatic cyc_a(input logic v, input logic [7:0] d, input logic r);
    logic exp_rdy, exp_tv;
    logic [31:0] w;
    bv_a = v;
    bd_a = d;
    tr_a = r;
    @(negedge clk);
    exp_rdy = !rst && !(pb.size() == 3 && wq.size() == 4);
    exp_tv = wq.size() != 0;
    chk("ready", rdy_a, exp_rdy);
    if (!rst) begin
      chk("tvalid", tv_a, exp_tv);
      chk("tdata", td_a, exp_tv ? wq[0] : 32'h0);
      chk("level", lvl_a, wq.size());
      chk("drop", drop_a, drop_m);
    end
    drop_m = 1'b0;
    if (rst) begin
      pb.delete();
      wq.delete();
      idle = 0;
    end else begin
      if (exp_tv && r) void'(wq.pop_front());
      if (v && exp_rdy) begin
        pb.push_back(d);
        idle = 0;
        if (pb.size() == 4) begin
          w = 32'h0;
          foreach (pb[k]) w |= 32'(pb[k]) << (8*(3-k));
          wq.push_back(w);
          pb.delete();
        end
      end else if (pb.size() != 0) begin
        idle++;
        if (idle == 10) begin
          pb.delete();
          idle = 0;
          drop_m = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pv, pr;
    rst = 1'b1;
    bv_a = 0; bd_a = 0; tr_a = 0;
    bv_b = 0; bd_b = 0; tr_b = 0;
    cyc_a(0, 8'h0, 0);
    cyc_a(0, 8'h0, 0);
    rst = 1'b0;
    cyc_a(0, 8'h0, 1);
    chk("b_reset_tvalid", tv_b, 0);
    chk("b_reset_level", lvl_b, 0);
    chk("b_reset_tdata", td_b, 0);
    chk("b_reset_drop", drop_b, 0);
    // back-to-back big-endian word
    cyc_a(1, 8'h12, 1);
    cyc_a(1, 8'h34, 1);
    cyc_a(1, 8'h56, 1);
    cyc_a(1, 8'h78, 1);
    chk("t1_word", td_a, 32'h12345678);
    chk("t1_valid", tv_a, 1);
    cyc_a(0, 8'h0, 1);
    chk("t1_gone", tv_a, 0);
    // little-endian 2-byte instance
    tr_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bv_b = 1'b1;
      bd_b = bs[i];
      chk("b_ready", rdy_b, 1);
      cyc_a(0, 8'h0, 1);
      if (i == 1) chk("b_first", td_b, 16'hBBAA);
    end
    bv_b = 1'b0;
    chk("b_level2", lvl_b, 2);
    chk("b_head", td_b, 16'hBBAA);
    tr_b = 1'b1;
    cyc_a(0, 8'h0, 1);
    chk("b_second", td_b, 16'hDDCC);
    chk("b_level1", lvl_b, 1);
    cyc_a(0, 8'h0, 1);
    chk("b_empty", tv_b, 0);
    chk("b_level0", lvl_b, 0);
    tr_b = 1'b0;
    // fill FIFO with tready low, stall on last byte of fifth word
    for (int i = 0; i < 20; i++) cyc_a(1, 8'(i + 1), 0);
    chk("t3_level", lvl_a, 4);
    chk("t3_blocked", rdy_a, 0);
    cyc_a(1, 8'd20, 0);
    cyc_a(1, 8'd20, 1);
    cyc_a(1, 8'd20, 1);
    for (int i = 0; i < 10; i++) cyc_a(0, 8'h0, 1'(i % 2));
    // timeout drops a partial word
    cyc_a(1, 8'h01, 1);
    cyc_a(1, 8'h02, 1);
    for (int i = 0; i < 10; i++) cyc_a(0, 8'h0, 1);
    chk("t4_drop", drop_a, 1);
    cyc_a(1, 8'h11, 1);
    chk("t4_pulse_end", drop_a, 0);
    cyc_a(1, 8'h22, 1);
    cyc_a(1, 8'h33, 1);
    cyc_a(1, 8'h44, 1);
    chk("t4_word", td_a, 32'h11223344);
    // byte on the expiry cycle wins
    cyc_a(1, 8'hA1, 1);
    for (int i = 0; i < 9; i++) cyc_a(0, 8'h0, 1);
    cyc_a(1, 8'hA2, 1);
    chk("t5_no_drop", drop_a, 0);
    cyc_a(1, 8'hA3, 1);
    cyc_a(1, 8'hA4, 1);
    chk("t5_word", td_a, 32'hA1A2A3A4);
    for (int i = 0; i < 50; i++) cyc_a(0, 8'h0, 1);
    // reset mid-operation
    for (int i = 0; i < 10; i++) cyc_a(1, 8'(8'h60 + i), 0);
    chk("t6_pre_level", lvl_a, 2);
    rst = 1'b1;
    cyc_a(1, 8'h55, 0);
    rst = 1'b0;
    chk("t6_tvalid", tv_a, 0);
    chk("t6_level", lvl_a, 0);
    cyc_a(1, 8'h9A, 1);
    cyc_a(1, 8'hBC, 1);
    cyc_a(1, 8'hDE, 1);
    cyc_a(1, 8'hF0, 1);
    chk("t6_word", td_a, 32'h9ABCDEF0);
    // random traffic with varying byte density and backpressure
    for (int c = 0; c < 8; c++) begin
      pv = int'($urandom_range(3, 95));
      pr = int'($urandom_range(10, 100));
      for (int i = 0; i < 60; i++)
        cyc_a(1'($urandom_range(0, 99) < pv), 8'($urandom), 1'($urandom_range(0, 99) < pr));
    end
    for (int i = 0; i < 8; i++) cyc_a(0, 8'h0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
